// File: rtl/gift_masked_pkg.sv
// Shared constants and helpers for the 3-share masked GIFT S-box datapath.
package gift_masked_pkg;

   localparam int SHARES         = 3;
   localparam int GIFT_SBOX_BITS = 4;
   localparam int CF_TERMS       = 18;

   // First term index of the block folded into share i (block width is terms/SHARES).
   function automatic int share_block_lo(input int share, input int terms);
      return share * (terms / SHARES);
   endfunction

   function automatic int share_block_len(input int terms);
      return terms / SHARES;
   endfunction

endpackage

// File: rtl/gift_cf_lane_compress.sv
// Combinational fold of one lane's expanded terms into three refreshed output shares.
module gift_cf_lane_compress
   import gift_masked_pkg::*;
#(
   parameter int TERMS = CF_TERMS
) (
   input  logic [TERMS-1:0] terms,
   input  logic [1:0]       rnd,
   output logic             y1,
   output logic             y2,
   output logic             y3
);

   localparam int BLK = share_block_len(TERMS);

   logic [SHARES-1:0] blk;

   for (genvar i = 0; i < SHARES; i++) begin : g_share
      localparam int LO = share_block_lo(i, TERMS);
      assign blk[i] = ^terms[LO +: BLK];
   end

   // r0 ^ r1 on the third share cancels the refresh in the recombined value.
   assign y1 = blk[0] ^ rnd[0];
   assign y2 = blk[1] ^ rnd[1];
   assign y3 = blk[2] ^ rnd[0] ^ rnd[1];

endmodule

// File: rtl/gift_sbox_cf_compress.sv
// Two-stage elastic compression of masked GIFT component-function terms into 3 shares.
module gift_sbox_cf_compress
   import gift_masked_pkg::*;
#(
   parameter int LANES = GIFT_SBOX_BITS,
   parameter int TERMS = CF_TERMS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*TERMS-1:0] terms,
   input  logic                   rnd_valid,
   input  logic [2*LANES-1:0]     rnd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES-1:0]       y1,
   output logic [LANES-1:0]       y2,
   output logic [LANES-1:0]       y3
);

   logic                   vld_p1;
   logic [LANES*TERMS-1:0] terms_p1;
   logic [2*LANES-1:0]     rnd_p1;
   logic [LANES-1:0]       c1, c2, c3;
   logic                   s1_load;
   logic                   s2_load;

   assign s2_load  = vld_p1 & (~out_valid | out_ready);
   assign in_ready = ~vld_p1 | ~out_valid | out_ready;
   assign s1_load  = in_valid & in_ready & rnd_valid;

   // Stage 1: glitch barrier, raw inputs straight into flops
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         terms_p1 <= '0;
         rnd_p1   <= '0;
      end else begin
         if (s1_load) begin
            terms_p1 <= terms;
            rnd_p1   <= rnd;
         end
         if (s1_load)
            vld_p1 <= 1'b1;
         else if (s2_load)
            vld_p1 <= 1'b0;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      gift_cf_lane_compress #(
         .TERMS(TERMS)
      ) u_lane (
         .terms(terms_p1[k*TERMS +: TERMS]),
         .rnd  (rnd_p1[2*k +: 2]),
         .y1   (c1[k]),
         .y2   (c2[k]),
         .y3   (c3[k])
      );
   end

   // Stage 2: registered output shares
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y1        <= '0;
         y2        <= '0;
         y3        <= '0;
      end else begin
         if (s2_load) begin
            y1 <= c1;
            y2 <= c2;
            y3 <= c3;
         end
         if (s2_load)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gift_sbox_cf_compress.sv
// Self-checking bench for gift_sbox_cf_compress: share-level reference model plus directed cases.
module tb_gift_sbox_cf_compress;

   localparam int LANES = 4;
   localparam int TERMS = 18;
   localparam int BLK   = TERMS / 3;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      logic [3:0] p;
   } exp_t;

   logic                   clk;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*TERMS-1:0] terms;
   logic                   rnd_valid;
   logic [2*LANES-1:0]     rnd;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES-1:0]       y1, y2, y3;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;
   exp_t q[$];

   gift_sbox_cf_compress dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .terms    (terms),
      .rnd_valid(rnd_valid),
      .rnd      (rnd),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: share i of lane k is the XOR of its six-term block plus its refresh bits.
   function automatic exp_t model(input logic [LANES*TERMS-1:0] t, input logic [2*LANES-1:0] r);
      exp_t e;
      logic [2:0] s;
      e = '0;
      for (int k = 0; k < LANES; k++) begin
         s = '0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < BLK; j++)
               s[i] = s[i] ^ t[k*TERMS + i*BLK + j];
         e.a[k] = s[0] ^ r[2*k];
         e.b[k] = s[1] ^ r[2*k+1];
         e.c[k] = s[2] ^ r[2*k] ^ r[2*k+1];
         e.p[k] = 1'b0;
         for (int j = 0; j < TERMS; j++)
            e.p[k] = e.p[k] ^ t[k*TERMS + j];
      end
      return e;
   endfunction

   // Single compare process: predicts transfers one half-cycle ahead of the edge they happen on.
   logic        hold_chk = 1'b0;
   logic [12:0] hold_val;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         hold_chk = 1'b0;
      end else begin
         if (hold_chk)
            check("hold", {19'd0, out_valid, y1, y2, y3}, {19'd0, hold_val});
         if (out_valid) begin
            check("occupancy", {31'd0, q.size() != 0}, 32'd1);
            if (out_valid && out_ready && q.size() != 0) begin
               e = q.pop_front();
               check("shares", {20'd0, y1, y2, y3}, {20'd0, e.a, e.b, e.c});
               check("unmasked", {28'd0, y1 ^ y2 ^ y3}, {28'd0, e.p});
            end
         end
         hold_chk = out_valid && !out_ready;
         hold_val = {1'b1, y1, y2, y3};
         if (in_valid && in_ready && rnd_valid) begin
            q.push_back(model(terms, rnd));
            n_acc++;
         end
         check("capacity", {31'd0, q.size() <= 2}, 32'd1);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic sample;
      @(negedge clk);
      #1;
   endtask

   // Single transfer into an empty pipe with out_ready=1; literal share expectations.
   task automatic xfer_one(input string name, input logic [LANES*TERMS-1:0] t, input logic [2*LANES-1:0] r,
                           input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3, input logic [3:0] ep);
      terms = t; rnd = r; in_valid = 1'b1; rnd_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      sample;
      check({name, "_lat"}, {31'd0, out_valid}, 32'd0);
      tick;
      sample;
      check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_y"}, {20'd0, y1, y2, y3}, {20'd0, e1, e2, e3});
      check({name, "_plain"}, {28'd0, y1 ^ y2 ^ y3}, {28'd0, ep});
      tick;
      sample;
      check({name, "_once"}, {31'd0, out_valid}, 32'd0);
      tick;
   endtask

   logic [LANES*TERMS-1:0] bp_t[3];
   logic [2*LANES-1:0]     bp_r[3];
   logic [LANES*TERMS-1:0] tv;
   logic [95:0]            rw;
   logic [11:0]            ysnap;
   int idx, sent, cyc, n0;
   logic acc;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
      terms = '0; rnd = '0;
      tick;
      tick;
      sample;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_y", {20'd0, y1, y2, y3}, 32'd0);
      tick;
      rst_n = 1'b1; out_ready = 1'b1;

      xfer_one("zero", '0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0);
      tv = '0; tv[0] = 1'b1;
      xfer_one("t0_r00", tv, 8'h00, 4'h1, 4'h0, 4'h0, 4'h1);
      xfer_one("t0_r03", tv, 8'h03, 4'h0, 4'h1, 4'h0, 4'h1);
      tv = '0; tv[71] = 1'b1;
      xfer_one("t71_r80", tv, 8'h80, 4'h0, 4'h8, 4'h0, 4'h8);
      tv = '0; tv[25] = 1'b1;
      xfer_one("t25_r04", tv, 8'h04, 4'h2, 4'h2, 4'h2, 4'h2);

      // Backpressure: three items offered, consumer stalled
      for (int i = 0; i < 3; i++) begin
         rw = {32'h1234_5678 * (i + 1), 32'h9abc_def0 ^ i, 32'hc3a5_0f1e + i};
         bp_t[i] = rw[71:0];
         bp_r[i] = 8'h5a + 8'(i * 37);
      end
      out_ready = 1'b0; idx = 0;
      in_valid = 1'b1; rnd_valid = 1'b1; terms = bp_t[0]; rnd = bp_r[0];
      for (int c = 0; c < 6; c++) begin
         sample;
         acc = in_ready;
         if (c == 2) ysnap = {y1, y2, y3};
         tick;
         if (acc) idx++;
         if (idx < 3) begin terms = bp_t[idx]; rnd = bp_r[idx]; end
      end
      sample;
      check("bp_captured", idx, 2);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_stable", {20'd0, y1, y2, y3}, {20'd0, ysnap});
      tick;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         sample;
         check("bp_drain", {31'd0, out_valid}, 32'd1);
         acc = in_valid && in_ready;
         tick;
         if (acc) in_valid = 1'b0;
      end
      sample;
      check("bp_empty", {31'd0, out_valid}, 32'd0);
      tick;

      // Randomness starvation
      n0 = n_acc;
      in_valid = 1'b1; rnd_valid = 1'b0; terms = bp_t[1]; rnd = 8'h11;
      tick; tick; tick;
      sample;
      check("starve_nocap", n_acc, n0);
      check("starve_out", {31'd0, out_valid}, 32'd0);
      check("starve_ready", {31'd0, in_ready}, 32'd1);
      tick;
      rnd_valid = 1'b1;
      sample;
      check("starve_cap", n_acc, n0 + 1);
      tick;
      in_valid = 1'b0; rnd_valid = 1'b0;
      tick;
      sample;
      check("starve_out2", {31'd0, out_valid}, 32'd1);
      tick;

      // Reset with both stages full
      out_ready = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1;
      terms = bp_t[0]; rnd = bp_r[0];
      tick;
      terms = bp_t[2]; rnd = bp_r[2];
      tick;
      in_valid = 1'b0;
      sample;
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      sample;
      check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst2_y", {20'd0, y1, y2, y3}, 32'd0);
      check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
      tick;
      out_ready = 1'b1;
      tv = '0; tv[0] = 1'b1;
      xfer_one("post_rst", tv, 8'h03, 4'h0, 4'h1, 4'h0, 4'h1);

      // Random stream against the model
      sent = 0; cyc = 0;
      rw = {$urandom(), $urandom(), $urandom()};
      terms = rw[71:0]; rnd = 8'($urandom());
      in_valid = 1'b1;
      while (sent < 1000 && cyc < 20000) begin
         rnd_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid) in_valid = ($urandom_range(0, 7) != 0);
         sample;
         acc = in_valid && in_ready && rnd_valid;
         tick;
         cyc++;
         if (acc) begin
            sent++;
            rw = {$urandom(), $urandom(), $urandom()};
            terms = rw[71:0]; rnd = 8'($urandom());
            in_valid = ($urandom_range(0, 7) != 0);
         end
      end
      check("rand_sent", sent, 1000);
      in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick;
      sample;
      check("rand_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
